// File: rtl/ccu_cd_router_if.sv
// CD router bundle: job push port, per-master CD channels,
// shared consumer forward bus and status.
interface ccu_cd_router_if #(
  parameter int NoMstPorts  = 4,
  parameter int NoUsers     = 2,
  parameter int FifoDepth   = 4,
  parameter int CdDataWidth = 64
);
  localparam int MstIdxW = $clog2(NoMstPorts);
  localparam int UsrIdxW = $clog2(NoUsers);
  localparam int CntW    = $clog2(FifoDepth + 1);

  logic                              push_valid_i;
  logic                              push_ready_o;
  logic [UsrIdxW-1:0]                push_user_i;
  logic [NoMstPorts-1:0]             push_avail_i;
  logic [MstIdxW-1:0]                push_first_i;
  logic [NoMstPorts-1:0]             cd_valid_i;
  logic [NoMstPorts-1:0]             cd_ready_o;
  logic [NoMstPorts*CdDataWidth-1:0] cd_data_i;
  logic [NoMstPorts-1:0]             cd_last_i;
  logic [NoUsers-1:0]                usr_valid_o;
  logic [NoUsers-1:0]                usr_ready_i;
  logic [CdDataWidth-1:0]            usr_data_o;
  logic                              usr_last_o;
  logic [MstIdxW-1:0]                usr_src_o;
  logic                              job_done_o;
  logic [CntW-1:0]                   count_o;
  logic                              proto_err_o;

  modport slave (
    input  push_valid_i, push_user_i, push_avail_i, push_first_i,
    input  cd_valid_i, cd_data_i, cd_last_i, usr_ready_i,
    output push_ready_o, cd_ready_o, usr_valid_o, usr_data_o,
    output usr_last_o, usr_src_o, job_done_o, count_o, proto_err_o
  );

  modport master (
    output push_valid_i, push_user_i, push_avail_i, push_first_i,
    output cd_valid_i, cd_data_i, cd_last_i, usr_ready_i,
    input  push_ready_o, cd_ready_o, usr_valid_o, usr_data_o,
    input  usr_last_o, usr_src_o, job_done_o, count_o, proto_err_o
  );
endinterface

// File: rtl/ccu_cd_router.sv
// In-order CD-channel router: forwards the head job's first
// responder to its consumer and drains the other responders.
module ccu_cd_router #(
  parameter int NoMstPorts  = 4,
  parameter int NoUsers     = 2,
  parameter int FifoDepth   = 4,
  parameter int CdBeats     = 2,
  parameter int CdDataWidth = 64
) (
  input logic            clk_i,
  input logic            rst_i,
  ccu_cd_router_if.slave bus
);
  localparam int MstIdxW = $clog2(NoMstPorts);
  localparam int UsrIdxW = $clog2(NoUsers);
  localparam int CntW    = $clog2(FifoDepth + 1);
  localparam int PtrW    = $clog2(FifoDepth);
  localparam int BeatW   = $clog2(CdBeats + 1);

  localparam logic [CntW-1:0]  Full    = CntW'(FifoDepth);
  localparam logic [BeatW-1:0] LastCnt = BeatW'(CdBeats - 1);
  localparam logic [BeatW-1:0] MaxCnt  = BeatW'(CdBeats);

  typedef struct packed {
    logic [UsrIdxW-1:0]    user;
    logic [NoMstPorts-1:0] avail;
    logic [MstIdxW-1:0]    first;
  } job_t;

  job_t                  mem [FifoDepth];
  logic [PtrW-1:0]       wr_ptr;
  logic [PtrW-1:0]       rd_ptr;
  logic [CntW-1:0]       count;
  logic [NoMstPorts-1:0] done;
  logic [BeatW-1:0]      beat_cnt [NoMstPorts];
  logic                  proto_err;

  job_t                   head;
  logic                   busy;
  logic                   push;
  logic                   pop;
  logic                   fwd_en;
  logic [NoMstPorts-1:0]  pend;
  logic [NoMstPorts-1:0]  cd_ready;
  logic [NoMstPorts-1:0]  acc;
  logic [NoMstPorts-1:0]  acc_last;
  logic [NoMstPorts-1:0]  beat_err;
  logic [NoUsers-1:0]     usr_valid;
  logic [CdDataWidth-1:0] usr_data;
  logic                   usr_last;
  logic [MstIdxW-1:0]     usr_src;

  assign busy   = (count != '0);
  assign head   = mem[rd_ptr];
  assign pend   = busy ? (head.avail & ~done) : '0;
  assign fwd_en = busy && pend[head.first];
  assign push   = bus.push_valid_i && (count != Full);

  // Non-first responders drain freely; the first waits on its consumer.
  always_comb begin
    cd_ready = pend;
    if (fwd_en) cd_ready[head.first] = bus.usr_ready_i[head.user];
  end

  always_comb begin
    usr_valid = '0;
    usr_data  = '0;
    usr_last  = 1'b0;
    usr_src   = '0;
    if (fwd_en && bus.cd_valid_i[head.first]) begin
      usr_valid[head.user] = 1'b1;
      usr_data = bus.cd_data_i[head.first*CdDataWidth +: CdDataWidth];
      usr_last = bus.cd_last_i[head.first];
      usr_src  = head.first;
    end
  end

  assign acc      = bus.cd_valid_i & cd_ready;
  assign acc_last = acc & bus.cd_last_i;
  assign pop      = busy && (((done | acc_last) & head.avail) == head.avail);

  always_comb begin
    beat_err = '0;
    for (int i = 0; i < NoMstPorts; i++) begin
      if (acc[i]) begin
        if (bus.cd_last_i[i]) beat_err[i] = (beat_cnt[i] != LastCnt);
        else                  beat_err[i] = (beat_cnt[i] >= LastCnt);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      done      <= '0;
      proto_err <= 1'b0;
      for (int i = 0; i < NoMstPorts; i++) beat_cnt[i] <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
      count <= count + CntW'(push) - CntW'(pop);
      done  <= pop ? '0 : (done | acc_last);
      if (|beat_err) proto_err <= 1'b1;
      // Saturate so an over-long burst keeps flagging until last.
      for (int i = 0; i < NoMstPorts; i++) begin
        if (acc[i]) begin
          if (bus.cd_last_i[i])          beat_cnt[i] <= '0;
          else if (beat_cnt[i] != MaxCnt) beat_cnt[i] <= beat_cnt[i] + BeatW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= '{user:  bus.push_user_i,
                       avail: bus.push_avail_i,
                       first: bus.push_first_i};
    end
  end

  assign bus.push_ready_o = (count != Full);
  assign bus.cd_ready_o   = cd_ready;
  assign bus.usr_valid_o  = usr_valid;
  assign bus.usr_data_o   = usr_data;
  assign bus.usr_last_o   = usr_last;
  assign bus.usr_src_o    = usr_src;
  assign bus.job_done_o   = pop;
  assign bus.count_o      = count;
  assign bus.proto_err_o  = proto_err;
endmodule
